// File: rtl/activation_requant.sv
// Post-layer requantizer: optional ReLU, then round-half-up and saturate each
// accumulator row back to datawidth bits, one row per cycle.
module activation_requant #(
  parameter int rows      = 30,
  parameter int columns   = 64,
  parameter int datawidth = 11,
  parameter int frac_bits = 5,
  localparam int ACCW = 2*datawidth + $clog2(columns),
  localparam int CW   = $clog2(rows+1)
) (
  input  logic                      clk,
  input  logic                      rst_overall,
  input  logic [rows*ACCW-1:0]      in_data,
  input  logic                      in_valid,
  input  logic                      relu_en,
  output logic                      in_ready,
  output logic [rows*datawidth-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CW-1:0]             sat_count,
  output logic                      overrun
);

  localparam int IW = (rows > 1) ? $clog2(rows) : 1;
  localparam logic signed [ACCW:0] RND     = (ACCW+1)'(2**frac_bits/2);
  localparam logic signed [ACCW:0] SAT_MAX = {{(ACCW+2-datawidth){1'b0}}, {(datawidth-1){1'b1}}};
  localparam logic signed [ACCW:0] SAT_MIN = {{(ACCW+2-datawidth){1'b1}}, {(datawidth-1){1'b0}}};

  // state_q is the observable FSM state for checkers.
  typedef enum logic [1:0] {IDLE = 2'd0, PROCESS = 2'd1, HOLD = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [rows*ACCW-1:0]      data_q, data_d;
  logic                      relu_q, relu_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [rows*datawidth-1:0] out_data_q, out_data_d;
  logic [CW-1:0]             sat_q, sat_d;
  logic                      overrun_q, overrun_d;

  logic signed [ACCW-1:0]    x;
  logic signed [ACCW:0]      sum;
  logic signed [ACCW:0]      r;
  logic [datawidth-1:0]      res;
  logic                      res_sat;

  // Single shared datapath for the row selected by idx_q.
  always_comb begin
    x       = data_q[(rows-1-int'(idx_q))*ACCW +: ACCW];
    sum     = {x[ACCW-1], x} + RND;
    r       = sum >>> frac_bits;
    res     = r[datawidth-1:0];
    res_sat = 1'b0;
    if (relu_q && x[ACCW-1]) begin
      res = '0;
    end else if (r > SAT_MAX) begin
      res     = SAT_MAX[datawidth-1:0];
      res_sat = 1'b1;
    end else if (r < SAT_MIN) begin
      res     = SAT_MIN[datawidth-1:0];
      res_sat = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    relu_d     = relu_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    sat_d      = sat_q;
    overrun_d  = overrun_q | (in_valid && (state_q != IDLE));
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          relu_d  = relu_en;
          sat_d   = '0;
          idx_d   = '0;
          state_d = PROCESS;
        end
      end
      PROCESS: begin
        out_data_d[(rows-1-int'(idx_q))*datawidth +: datawidth] = res;
        if (res_sat) sat_d = sat_q + CW'(1);
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(rows-1)) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      state_q    <= IDLE;
      data_q     <= '0;
      relu_q     <= 1'b0;
      idx_q      <= '0;
      out_data_q <= '0;
      sat_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      relu_q     <= relu_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign sat_count = sat_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/activation_requant.md
# activation_requant

Post-layer stage that consumes the packed accumulator vector produced by a `layer` instance when its `done` pulses. It applies an optional ReLU to each row and rounds and saturates the result back to `datawidth` bits. The packed output drives the `values` input of the next `layer` instance, whose `columns` equals this block's `rows`. Rows are processed serially, one per cycle, which keeps a single rounding/saturation datapath regardless of `rows`.

## Interface
- `rows`, 30: number of accumulator elements; equals the upstream layer's `rows`.
- `columns`, 64: upstream layer's `columns`; sets the accumulator width ACCW = 2*datawidth + $clog2(columns).
- `datawidth`, 11: signed output element width; equals the upstream layer's `datawidth`.
- `frac_bits`, 5: fractional bits per operand. The accumulator carries 2*frac_bits fractional bits, so the requantize shift is `frac_bits`. Legal range is 0..datawidth-1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_overall`  in  1  asynchronous, active-high reset.
- `in_data`  in  rows*ACCW  upstream `out`; row k occupies bits [(rows-k-1)*ACCW +: ACCW].
- `in_valid`  in  1  upstream `done`; a one-cycle pulse with no backpressure.
- `relu_en`  in  1  1 = apply ReLU; 0 = bypass (final layer). Sampled on the capture cycle.
- `in_ready`  out  1  high only in IDLE.
- `out_data`  out  rows*datawidth  row k occupies bits [(rows-k-1)*datawidth +: datawidth].
- `out_valid`  out  1  result available; held until accepted.
- `out_ready`  in  1  downstream accepts `out_data` on a cycle where `out_valid && out_ready`.
- `sat_count`  out  $clog2(rows+1)  number of elements saturated in the last vector.
- `overrun`  out  1  sticky; set when `in_valid` arrives while `in_ready` = 0.

## Operation
- FSM states: IDLE, PROCESS, HOLD.
  - IDLE: on `in_valid`, capture `in_data` into an internal register, latch `relu_en`, clear `sat_count` and the row counter, then go to PROCESS.
  - PROCESS: each cycle, compute row `idx` and write it into the `out_data` register; `idx` increments. After row rows-1 is written, go to HOLD.
  - HOLD: `out_valid` = 1. On `out_valid && out_ready`, go to IDLE.
- Per-element arithmetic, with x = signed ACCW value:
  - If the latched `relu_en` = 1 and x < 0, the result is 0 and saturation is not counted.
  - Otherwise compute r = (x + (frac_bits > 0 ? 2^(frac_bits-1) : 0)) >>> frac_bits. The addition is done in ACCW+1 bits so it cannot overflow. Rounding is round-half-up, toward +inf on exact halves.
  - If r > 2^(datawidth-1)-1, the result is 2^(datawidth-1)-1. If r < -2^(datawidth-1), the result is -2^(datawidth-1). Either case increments `sat_count`.
  - Otherwise the result is r[datawidth-1:0].
- `out_data` rows not yet rewritten in PROCESS keep their previous vector's values. `out_data` is only meaningful while `out_valid` = 1.
- `in_valid` in PROCESS or HOLD:
  - The pulse is dropped and `overrun` is set.
  - The captured vector and in-progress work are unaffected.
  - `overrun` is cleared only by reset.
- `relu_en` changes after the capture cycle have no effect until the next capture.

## Timing
- Reset values: state IDLE, `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `sat_count` = 0, `overrun` = 0, internal registers 0.
- Asserting `rst_overall` in any state, including mid-PROCESS or HOLD, applies the reset values immediately and abandons the vector.
- Capture edge = edge E (IDLE with `in_valid` = 1). Row k is written at edge E+1+k.
- `out_valid` rises after edge E+rows, i.e. latency from the `in_valid` edge to `out_valid` is rows+1 cycles. With defaults that is 31 cycles.
- Handshake:
  - If `out_ready` = 1 on the first HOLD cycle, `out_valid` is high for exactly one cycle.
  - On the accept edge `out_valid` falls and the block is back in IDLE with `in_ready` = 1.
  - A new `in_valid` is accepted no earlier than the cycle after acceptance.
- Minimum spacing between two accepted vectors is rows+2 cycles.
- `in_ready` is low from edge E through the accept edge.

## Test plan
All scenarios use rows=4, columns=64, datawidth=11, frac_bits=5, ACCW=28.
- Rounding: in rows {100, 48, -48, -100}, relu_en=0, out_ready=1 -> out {3, 2, -1, -3}, sat_count=0. out_valid is high exactly one cycle, 5 cycles after the capture edge.
- ReLU and saturation: in rows {-100, 2^20, -2^20, 31}, relu_en=1 -> out {0, 1023, 0, 1}, sat_count=1. Repeat with relu_en=0 -> {-3, 1023, -1024, 1}, sat_count=2.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> out_valid and out_data stable and in_ready=0 throughout. Raise out_ready -> out_valid falls on the next edge and in_ready=1.
- Overrun: a second in_valid pulse during PROCESS with different data -> overrun=1 (sticky) and the output equals the first vector only. After acceptance, a new pulse is processed normally with overrun still 1.
- Reset mid-operation: assert rst_overall two cycles into PROCESS -> out_valid=0, out_data=0, sat_count=0, overrun=0 and in_ready=1 asynchronously. The next vector completes with the normal rows+1 latency.
- relu_en change: relu_en=1 at capture, then 0 during PROCESS, with input row -100 -> output 0.
